// File: rtl/rps_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rps_round_ctrl : rock-paper-scissors round sequencer with tick countdown     |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module rps_round_ctrl #(
    parameter int COUNT_START = 3,
    parameter int HOLD_TICKS  = 2,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_in,
    input  logic               start,
    input  logic               clear_score,
    input  logic [1:0]         p1_sel,
    input  logic [1:0]         p2_sel,
    output logic [2:0]         countdown,
    output logic               busy,
    output logic [1:0]         result,
    output logic               result_valid,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_JUDGE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [2:0]         c_count_start = 3'(COUNT_START);
    localparam logic [2:0]         c_hold_ticks  = 3'(HOLD_TICKS);
    localparam logic [SCORE_W-1:0] c_score_max   = '1;

    state_t     r_state;
    logic       r_tick_s1, r_tick_s2, r_tick_d;
    logic [1:0] r_vld;
    logic       r_armed;
    logic [2:0] r_hold;
    logic       w_tick_rise;
    logic [1:0] w_verdict;

    // r_armed blocks a rise until a real low has been seen after reset,
    // so a tick_in already high at reset release does not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_s1 <= 1'b0;
            r_tick_s2 <= 1'b0;
            r_tick_d  <= 1'b0;
            r_vld     <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_tick_s1 <= tick_in;
            r_tick_s2 <= r_tick_s1;
            r_tick_d  <= r_tick_s2;
            r_vld     <= {r_vld[0], 1'b1};
            r_armed   <= r_armed | (r_vld[1] & ~r_tick_s2);
        end
    end

    assign w_tick_rise = r_tick_s2 & ~r_tick_d & r_armed;

    always_comb begin
        w_verdict = 2'b11;
        if (p1_sel == p2_sel)
            w_verdict = 2'b11;
        else if (p1_sel == 2'b00)
            w_verdict = 2'b10;
        else if (p2_sel == 2'b00)
            w_verdict = 2'b01;
        else if ((p1_sel == 2'b01 && p2_sel == 2'b11) ||
                 (p1_sel == 2'b11 && p2_sel == 2'b10) ||
                 (p1_sel == 2'b10 && p2_sel == 2'b01))
            w_verdict = 2'b01;
        else
            w_verdict = 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            countdown    <= 3'd0;
            busy         <= 1'b0;
            result       <= 2'b00;
            result_valid <= 1'b0;
            r_hold       <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_COUNT;
                        countdown    <= c_count_start;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (w_tick_rise) begin
                        countdown <= countdown - 3'd1;
                        if (countdown == 3'd1)
                            r_state <= S_JUDGE;
                    end
                end
                S_JUDGE: begin
                    result       <= w_verdict;
                    result_valid <= 1'b1;
                    r_hold       <= c_hold_ticks;
                    r_state      <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_tick_rise) begin
                        r_hold <= r_hold - 3'd1;
                        if (r_hold == 3'd1) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Clear has priority over a same-cycle judge increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score1 <= '0;
            score2 <= '0;
        end else if (clear_score) begin
            score1 <= '0;
            score2 <= '0;
        end else if (r_state == S_JUDGE) begin
            if (w_verdict == 2'b01 && score1 != c_score_max)
                score1 <= score1 + 1'b1;
            if (w_verdict == 2'b10 && score2 != c_score_max)
                score2 <= score2 + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rps_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rps_round_ctrl : directed self-checking bench for rps_round_ctrl          |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module tb_rps_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       start = 1'b0;
    logic       clear_score = 1'b0;
    logic [1:0] p1_sel = 2'b00;
    logic [1:0] p2_sel = 2'b00;
    logic [2:0] countdown;
    logic       busy;
    logic [1:0] result;
    logic       result_valid;
    logic [3:0] score1;
    logic [3:0] score2;

    int vectors = 0;
    int miscompares = 0;

    rps_round_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_in      (tick_in),
        .start        (start),
        .clear_score  (clear_score),
        .p1_sel       (p1_sel),
        .p2_sel       (p2_sel),
        .countdown    (countdown),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .score1       (score1),
        .score2       (score2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_in = 1'b1;
        step(4);
        tick_in = 1'b0;
        step(4);
    endtask

    // Final countdown tick: selections are presented only for the JUDGE edge,
    // then scrambled on the following cycle.
    task automatic judge_tick(input logic [1:0] a1, input logic [1:0] a2, input logic clr);
        tick_in = 1'b1;
        step(3);
        p1_sel      = a1;
        p2_sel      = a2;
        clear_score = clr;
        step(1);
        p1_sel      = ~a1;
        p2_sel      = ~a2;
        clear_score = 1'b0;
        tick_in     = 1'b0;
        step(4);
    endtask

    task automatic play_round(input logic [1:0] a1, input logic [1:0] a2, input logic clr);
        start = 1'b1;
        step(1);
        start = 1'b0;
        tick();
        tick();
        judge_tick(a1, a2, clr);
        tick();
        tick();
    endtask

    initial begin
        #12;
        chk("rst_countdown", 32'(countdown), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_score1", 32'(score1), 0);
        chk("rst_score2", 32'(score2), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(5);

        // Round 1: rock vs scissors, full walk-through
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("r1_cd3", 32'(countdown), 3);
        chk("r1_busy", 32'(busy), 1);
        chk("r1_valid0", 32'(result_valid), 0);
        tick();
        chk("r1_cd2", 32'(countdown), 2);
        tick();
        chk("r1_cd1", 32'(countdown), 1);
        judge_tick(2'b01, 2'b11, 1'b0);
        chk("r1_cd0", 32'(countdown), 0);
        chk("r1_result", 32'(result), 1);
        chk("r1_valid", 32'(result_valid), 1);
        chk("r1_score1", 32'(score1), 1);
        chk("r1_score2", 32'(score2), 0);
        tick();
        chk("r1_hold_busy", 32'(busy), 1);
        tick();
        chk("r1_idle_busy", 32'(busy), 0);
        chk("r1_idle_result", 32'(result), 1);
        chk("r1_idle_valid", 32'(result_valid), 1);

        play_round(2'b10, 2'b10, 1'b0);
        chk("r2_draw", 32'(result), 3);
        chk("r2_score1", 32'(score1), 1);
        chk("r2_score2", 32'(score2), 0);

        play_round(2'b00, 2'b01, 1'b0);
        chk("r3_p2win", 32'(result), 2);
        chk("r3_score2", 32'(score2), 1);

        play_round(2'b00, 2'b00, 1'b0);
        chk("r4_draw", 32'(result), 3);
        chk("r4_score1", 32'(score1), 1);
        chk("r4_score2", 32'(score2), 1);

        // Selections during COUNT would give a p2 win; JUDGE values give p1
        p1_sel = 2'b01;
        p2_sel = 2'b10;
        play_round(2'b11, 2'b10, 1'b0);
        chk("r5_judge_only", 32'(result), 1);
        chk("r5_score1", 32'(score1), 2);

        play_round(2'b01, 2'b11, 1'b1);
        chk("r6_clr_result", 32'(result), 1);
        chk("r6_clr_score1", 32'(score1), 0);
        chk("r6_clr_score2", 32'(score2), 0);

        // Start pulses during COUNT and HOLD are ignored
        start = 1'b1;
        step(1);
        start = 1'b0;
        tick();
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("r7_count_nostart", 32'(countdown), 2);
        tick();
        judge_tick(2'b10, 2'b11, 1'b0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        tick();
        chk("r7_hold_busy", 32'(busy), 1);
        tick();
        chk("r7_idle", 32'(busy), 0);
        chk("r7_result", 32'(result), 2);
        chk("r7_score2", 32'(score2), 1);

        // Held start restarts on the first edge back in IDLE
        start = 1'b1;
        step(1);
        tick();
        tick();
        judge_tick(2'b01, 2'b11, 1'b0);
        tick();
        tick();
        chk("r8_restart_cd", 32'(countdown), 3);
        chk("r8_restart_busy", 32'(busy), 1);
        chk("r8_restart_valid", 32'(result_valid), 0);
        chk("r8_score1", 32'(score1), 1);
        start = 1'b0;
        tick();
        chk("r8_cd2", 32'(countdown), 2);

        rst_n = 1'b0;
        #1;
        chk("mid_rst_cd", 32'(countdown), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_valid", 32'(result_valid), 0);
        chk("mid_rst_score1", 32'(score1), 0);
        chk("mid_rst_score2", 32'(score2), 0);

        // tick_in high across reset release must not produce a tick
        tick_in = 1'b1;
        step(2);
        rst_n = 1'b1;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(6);
        chk("no_phantom_tick", 32'(countdown), 3);
        tick_in = 1'b0;
        step(4);
        tick();
        chk("post_rst_cd2", 32'(countdown), 2);
        tick();
        judge_tick(2'b01, 2'b11, 1'b0);
        tick();
        tick();
        chk("sat_first", 32'(score1), 1);

        for (int i = 0; i < 14; i++)
            play_round(2'b01, 2'b11, 1'b0);
        chk("sat_15", 32'(score1), 15);
        play_round(2'b01, 2'b11, 1'b0);
        chk("sat_hold15", 32'(score1), 15);
        chk("sat_result", 32'(result), 1);
        chk("sat_score2", 32'(score2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rps_round_ctrl.md
RPS_ROUND_CTRL -- requirements
Module: rps_round_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter COUNT_START, default 3: number of tick periods in the countdown; legal range 1..7.
REQ-003 Parameter HOLD_TICKS, default 2: number of tick periods the result is held before returning to IDLE; legal range 1..7.
REQ-004 Parameter SCORE_W, default 4: width of each score counter.
REQ-005 clk  input  1  system clock (50 MHz board clock).
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 tick_in  input  1  divided slow clock, treated as data; each rising edge is one time unit.
REQ-008 start  input  1  level; requests a round, sampled only in IDLE.
REQ-009 clear_score  input  1  synchronous clear of both scores.
REQ-010 p1_sel, p2_sel  input  2 each  player choice: 00 none, 01 rock, 10 paper, 11 scissors.
REQ-011 countdown  output  3  remaining countdown value.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 result  output  2  00 none, 01 player 1 wins, 10 player 2 wins, 11 draw.
REQ-014 result_valid  output  1  high while result holds a judged round.
REQ-015 score1, score2  output  SCORE_W each  accumulated wins.

Function
REQ-016 tick_in SHALL pass through a 2-flop synchronizer plus one edge register; tick_rise SHALL be a single-clk pulse per tick_in rising edge.
REQ-017 The FSM SHALL have four states: IDLE, COUNT, JUDGE and HOLD.
REQ-018 IDLE with start=1 at a clk edge SHALL go to COUNT, load countdown=COUNT_START and clear result_valid.
REQ-019 In COUNT, each tick_rise SHALL decrement countdown by 1; the tick_rise that takes countdown from 1 to 0 SHALL move the FSM to JUDGE.
REQ-020 JUDGE SHALL last exactly one clk cycle. In that cycle it SHALL sample p1_sel and p2_sel, write result, set result_valid=1, update the scores, load the hold counter with HOLD_TICKS and go to HOLD.
REQ-021 Judging rules: rock beats scissors, scissors beats paper, paper beats rock, and equal valid choices are a draw.
REQ-022 A player with selection 00 SHALL lose to any valid choice; if both players are 00 the result SHALL be a draw.
REQ-023 A win SHALL increment the winner's score by 1; a draw SHALL leave both scores unchanged.
REQ-024 Scores SHALL saturate at 2^SCORE_W-1 and SHALL never wrap.
REQ-025 In HOLD, each tick_rise SHALL decrement the hold counter; when it reaches 0 the FSM SHALL return to IDLE.
REQ-026 result and result_valid SHALL stay unchanged through HOLD and IDLE until the next start is accepted.
REQ-027 start SHALL be ignored outside IDLE; a start held high continuously SHALL begin a new round on the first clk edge back in IDLE.
REQ-028 Selection changes outside the JUDGE cycle SHALL have no effect.
REQ-029 clear_score=1 SHALL zero both scores on the next clk edge in any state; if it coincides with a JUDGE increment, the clear SHALL win.
REQ-030 countdown SHALL read 0 in IDLE, JUDGE and HOLD.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, countdown 0, busy 0, result 00, result_valid 0, score1 0, score2 0, and all synchronizer and counter flops 0.
REQ-033 Reset asserted mid-round SHALL abort the round with no score update.
REQ-034 After rst_n deasserts, the first tick_rise SHALL occur only on a subsequent genuine 0-to-1 transition of tick_in.

Verification
REQ-035 Default parameters; start pulse; p1=01, p2=11; 3 ticks -> countdown 3,2,1,0; result=01, result_valid=1, score1=1; IDLE after 2 more ticks.
REQ-036 p1=10, p2=10 -> result=11, scores unchanged; p1=00, p2=01 -> result=10, score2 +1; p1=00, p2=00 -> result=11.
REQ-037 SCORE_W=4: 16 consecutive player-1 wins -> score1 reaches 15 and stays at 15.
REQ-038 clear_score asserted in the JUDGE cycle of a p1 win -> score1=0 afterwards.
REQ-039 Selections change during COUNT and again one cycle after JUDGE -> result reflects only the values present in the JUDGE cycle.
REQ-040 start pulsed during COUNT and during HOLD -> no restart; rst_n pulsed low at countdown=2 -> all outputs return to reset values and scores remain 0.
